// File: rtl/rou_stream_buffer.sv
// Multi-set twiddle-factor line buffer with an internal ascending/descending address sequencer.
// Lines stream out through a 2-cycle read pipeline into a 2-entry skid FIFO under valid/ready.
module rou_stream_buffer #(
  parameter int unsigned BIT_WIDTH  = 64,
  parameter int unsigned LINE_SIZE  = 4,
  parameter int unsigned COL_WIDTH  = BIT_WIDTH / 2,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned NUM_SETS   = 2,
  localparam int unsigned SET_W     = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int unsigned NUM_COLS  = 2 * LINE_SIZE,
  localparam int unsigned LINE_W    = BIT_WIDTH * LINE_SIZE
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_COLS-1:0]   wr_we,
  input  logic [SET_W-1:0]      wr_set,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [COL_WIDTH-1:0]  wr_din,
  input  logic                  start,
  input  logic [SET_W-1:0]      start_set,
  input  logic                  start_inv,
  input  logic [ADDR_WIDTH-1:0] start_base,
  input  logic [ADDR_WIDTH:0]   start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  line_valid,
  input  logic                  line_ready,
  output logic [LINE_W-1:0]     line_data,
  output logic                  err_start
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   MaxLen  = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] AddrOne = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CntOne  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [SET_W-1:0]      set_q, set_d;
  logic                  inv_q, inv_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;

  logic                  s1_valid_q, s1_valid_d;
  logic [LINE_W-1:0]     s1_data_q;
  logic [LINE_W-1:0]     fifo_q [2];
  logic [LINE_W-1:0]     fifo_d [2];
  logic [1:0]            fifo_cnt_q, fifo_cnt_d;

  logic                  pop;
  logic [1:0]            cnt_after_pop;
  logic [1:0]            occ_next;
  logic                  issue;
  logic                  len_legal;
  logic                  wr_set_ok;
  logic [ADDR_WIDTH:0]   cnt_inc;

  logic [LINE_W-1:0]     mem [NUM_SETS][Depth];

  assign pop           = (fifo_cnt_q != 2'd0) && line_ready;
  assign cnt_after_pop = fifo_cnt_q - {1'b0, pop};
  // Occupancy next cycle: what stays in the FIFO plus the read landing from stage 1.
  assign occ_next      = cnt_after_pop + {1'b0, s1_valid_q};
  assign issue         = (state_q == StRun) && (occ_next < 2'd2);
  assign len_legal     = (start_len != '0) && (start_len <= MaxLen);
  assign wr_set_ok     = 32'(wr_set) < NUM_SETS;
  assign cnt_inc       = cnt_q + CntOne;

  // Table storage: column-masked writes, read-first registered read.
  always_ff @(posedge clk) begin
    if (wr_set_ok) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        if (wr_we[i]) begin
          mem[wr_set][wr_addr][i*COL_WIDTH +: COL_WIDTH] <= wr_din;
        end
      end
    end
    if (issue) begin
      s1_data_q <= mem[set_q][addr_q];
    end
  end

  always_comb begin
    fifo_d[0]  = fifo_q[0];
    fifo_d[1]  = fifo_q[1];
    fifo_cnt_d = occ_next;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
    end
    if (s1_valid_q) begin
      fifo_d[cnt_after_pop[0]] = s1_data_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    set_d      = set_q;
    inv_d      = inv_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    s1_valid_d = issue;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_legal) begin
            state_d = StRun;
            busy_d  = 1'b1;
            err_d   = 1'b0;
            set_d   = start_set;
            inv_d   = start_inv;
            len_d   = start_len;
            cnt_d   = '0;
            // Descending streams begin at the top line; the subtraction wraps modulo depth.
            addr_d  = start_inv ? (start_base + start_len[ADDR_WIDTH-1:0] - AddrOne)
                                : start_base;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StRun: begin
        if (start) begin
          err_d = 1'b1;
        end
        if (issue) begin
          addr_d = inv_q ? (addr_q - AddrOne) : (addr_q + AddrOne);
          cnt_d  = cnt_inc;
          if (cnt_inc == len_q) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (start) begin
          err_d = 1'b1;
        end
        // Last line leaves the FIFO on this edge with nothing behind it.
        if (!s1_valid_q && (cnt_after_pop == 2'd0)) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      set_q      <= '0;
      inv_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      s1_valid_q <= 1'b0;
      fifo_q[0]  <= '0;
      fifo_q[1]  <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      set_q      <= set_d;
      inv_q      <= inv_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      s1_valid_q <= s1_valid_d;
      fifo_q[0]  <= fifo_d[0];
      fifo_q[1]  <= fifo_d[1];
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err_start  = err_q;
  assign line_valid = (fifo_cnt_q != 2'd0);
  assign line_data  = fifo_q[0];

endmodule

// File: tb/tb_rou_stream_buffer.sv
// Directed bench for rou_stream_buffer: table programming, ordered streams, backpressure,
// collisions, start errors and mid-stream reset.
module tb_rou_stream_buffer;

  localparam int Depth = 512;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [7:0]   wr_we = '0;
  logic [0:0]   wr_set = '0;
  logic [8:0]   wr_addr = '0;
  logic [31:0]  wr_din = '0;
  logic         start = 1'b0;
  logic [0:0]   start_set = '0;
  logic         start_inv = 1'b0;
  logic [8:0]   start_base = '0;
  logic [9:0]   start_len = '0;
  logic         busy, done, line_valid, err_start;
  logic         line_ready = 1'b1;
  logic [255:0] line_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [255:0] exp_mem [2][512];
  logic [255:0] exp_q [$];

  rou_stream_buffer dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr_we      (wr_we),
    .wr_set     (wr_set),
    .wr_addr    (wr_addr),
    .wr_din     (wr_din),
    .start      (start),
    .start_set  (start_set),
    .start_inv  (start_inv),
    .start_base (start_base),
    .start_len  (start_len),
    .busy       (busy),
    .done       (done),
    .line_valid (line_valid),
    .line_ready (line_ready),
    .line_data  (line_data),
    .err_start  (err_start)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] colval(input int s, input int a, input int c);
    return {4'(s), 12'(a), 16'(16'hC000 + c)};
  endfunction

  task automatic wr(input int s, input int a, input logic [7:0] we, input logic [31:0] d);
    wr_we   = we;
    wr_set  = 1'(s);
    wr_addr = 9'(a);
    wr_din  = d;
    for (int c = 0; c < 8; c++) begin
      if (we[c]) exp_mem[s][a][c*32 +: 32] = d;
    end
    tick();
    wr_we = '0;
  endtask

  task automatic prog_line(input int s, input int a);
    for (int c = 0; c < 8; c++) wr(s, a, 8'(1 << c), colval(s, a, c));
  endtask

  // Runs one stream and checks ordering, latency, stall stability and done timing.
  // poke_k >= 0 issues a stray start at that cycle; coll writes set1 line 3 on the first issue.
  task automatic run_stream(input string tag, input int set, input bit inv, input int base,
                            input int len, input bit rnd, input int poke_k, input bit coll);
    int           k, n, first_k, last_k, early, limit;
    bit           rdy, stall;
    logic [255:0] prev;
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      int a;
      a = inv ? (base + len - 1 - i) % Depth : (base + i) % Depth;
      exp_q.push_back(exp_mem[set][a]);
    end
    start      = 1'b1;
    start_set  = 1'(set);
    start_inv  = inv;
    start_base = 9'(base);
    start_len  = 10'(len);
    line_ready = 1'b1;
    tick();
    start   = 1'b0;
    k       = 0;
    n       = 0;
    first_k = -1;
    last_k  = -1;
    early   = 0;
    stall   = 1'b0;
    prev    = '0;
    limit   = 20 * len + 50;
    while (n < len && k < limit) begin
      if (k == 0) begin
        check({tag, " busy"}, busy, 1);
        check({tag, " err_clr"}, err_start, 0);
        check({tag, " done_low"}, done, 0);
      end
      if (coll && k == 0) begin
        wr_we   = 8'b0000_0011;
        wr_set  = 1'b1;
        wr_addr = 9'd3;
        wr_din  = 32'hDEAD_BEEF;
        exp_mem[1][3][63:0] = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
      end else if (coll && k == 1) begin
        wr_we = '0;
      end
      start = (k == poke_k);
      if (poke_k >= 0 && k == poke_k + 1) check({tag, " err_run"}, err_start, 1);
      if (stall) begin
        check({tag, " stall_valid"}, line_valid, 1);
        check({tag, " stall_data"}, line_data, prev);
      end
      if (line_valid && first_k < 0) first_k = k;
      if (done) early++;
      rdy        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      line_ready = rdy;
      if (line_valid && rdy) begin
        check($sformatf("%s line%0d", tag, n), line_data, exp_q[n]);
        n++;
        last_k = k;
      end
      stall = line_valid && !rdy;
      prev  = line_data;
      tick();
      k++;
    end
    start      = 1'b0;
    line_ready = 1'b1;
    check({tag, " count"}, n, len);
    check({tag, " first_valid"}, first_k, 2);
    if (!rnd) check({tag, " last_hs"}, last_k, len + 1);
    check({tag, " early_done"}, early, 0);
    check({tag, " done"}, done, 1);
    check({tag, " busy_end"}, busy, 0);
    check({tag, " valid_end"}, line_valid, 0);
    if (poke_k >= 0) check({tag, " err_sticky"}, err_start, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst valid", line_valid, 0);
    check("rst data", line_data, 0);
    check("rst err", err_start, 0);
    rstn = 1'b1;
    tick();

    for (int a = 0; a < 64; a++) prog_line(0, a);
    prog_line(0, 510);
    prog_line(0, 511);
    for (int a = 0; a < 8; a++) prog_line(1, a);

    run_stream("asc8", 0, 1'b0, 0, 8, 1'b0, -1, 1'b0);
    run_stream("desc8", 0, 1'b1, 0, 8, 1'b0, -1, 1'b0);
    run_stream("wrap_asc", 0, 1'b0, 510, 4, 1'b0, -1, 1'b0);
    run_stream("wrap_desc", 0, 1'b1, 510, 4, 1'b0, -1, 1'b0);
    run_stream("set1", 1, 1'b0, 0, 8, 1'b0, -1, 1'b0);
    run_stream("rand64", 0, 1'b0, 0, 64, 1'b1, -1, 1'b0);
    run_stream("poke", 0, 1'b0, 8, 8, 1'b0, 3, 1'b0);
    run_stream("coll_old", 1, 1'b0, 3, 1, 1'b0, -1, 1'b1);
    run_stream("set1_l3_new", 1, 1'b0, 3, 1, 1'b0, -1, 1'b0);
    run_stream("set0_l3", 0, 1'b0, 3, 1, 1'b0, -1, 1'b0);

    start      = 1'b1;
    start_set  = 1'b0;
    start_inv  = 1'b0;
    start_base = '0;
    start_len  = '0;
    tick();
    start = 1'b0;
    check("len0 err", err_start, 1);
    check("len0 busy", busy, 0);
    tick();
    check("len0 busy2", busy, 0);
    check("len0 valid", line_valid, 0);
    start     = 1'b1;
    start_len = 10'd513;
    tick();
    start = 1'b0;
    check("len513 err", err_start, 1);
    check("len513 busy", busy, 0);

    start      = 1'b1;
    start_base = '0;
    start_len  = 10'd64;
    line_ready = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("pre_rst valid", line_valid, 1);
    check("pre_rst busy", busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst valid", line_valid, 0);
    check("mid_rst busy", busy, 0);
    check("mid_rst data", line_data, 0);
    #2 rstn = 1'b1;
    tick();
    check("post_rst valid", line_valid, 0);
    run_stream("post_rst", 0, 1'b0, 16, 8, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
